// File: rtl/mssd_pkg.sv
// Shared types for the port byte packer: port id, byte width and the
// {port, byte} FIFO entry.
package mssd_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_t;

  typedef struct packed {
    port_t             port;
    logic [BYTE_W-1:0] data;
  } entry_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous {port, byte} FIFO with a registered head entry and full/empty
// flags. The caller only pushes when there is room or a pop happens on the same edge.
module byte_fifo
  import mssd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   empty,
  output logic   full,
  output entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count_nxt;
  logic          do_pop;
  entry_t        head_q;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = pop && !empty;
  assign rd_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  assign head   = head_q;

  always_comb begin
    count_nxt = count;
    case ({push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // The head register looks ahead: a push landing in the slot that becomes
  // the head is forwarded directly, since mem is not yet written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (count_nxt == '0)
        head_q <= '0;
      else if (push && (wr_ptr == rd_nxt))
        head_q <= push_entry;
      else
        head_q <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/port_byte_packer.sv
// Packs demuxed single-bit payloads into LSB-first bytes tagged with their port
// and queues them. Define BYTE_STATS_EN to add per-port pushed-byte counters.
//
// state     | meaning
// S_IDLE    | no byte in progress, bit counter is zero
// S_COLLECT | valid bits streaming, partial byte held in shreg/bit_cnt
module port_byte_packer
  import mssd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_pn,
  input  logic [3:0]  in_p,
  input  logic        in_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_port,
  output logic [7:0]  out_data,
  output logic        overflow,
  output logic        frag
`ifdef BYTE_STATS_EN
  ,
  output logic [15:0] byte_cnt0,
  output logic [15:0] byte_cnt1,
  output logic [15:0] byte_cnt2,
  output logic [15:0] byte_cnt3
`endif
);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] shreg;
  port_t             cur_port;
  logic              overflow_q;
  logic              frag_q;

  logic   bit_in;
  logic   take;
  logic   restart;
  logic   [2:0] eff_cnt;
  logic   push_req;
  logic   push_ok;
  logic   pop;
  logic   fifo_empty;
  logic   fifo_full;
  entry_t push_entry;
  entry_t head;

  assign bit_in   = in_p[in_pn];
  assign take     = in_valid && !in_error;
  // A port switch mid-byte abandons the partial byte and restarts with this bit.
  assign restart  = (state == S_COLLECT) && (bit_cnt != 3'd0) && (in_pn != cur_port);
  assign eff_cnt  = restart ? 3'd0 : bit_cnt;
  assign push_req = take && (eff_cnt == 3'(BYTE_W-1));
  assign push_entry = '{port: in_pn, data: {bit_in, shreg}};

  assign pop     = !fifo_empty && out_ready;
  assign push_ok = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      cur_port   <= '0;
      overflow_q <= 1'b0;
      frag_q     <= 1'b0;
    end else begin
      frag_q <= 1'b0;
      if (push_req && !push_ok) overflow_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take) begin
            state    <= S_COLLECT;
            shreg    <= {bit_in, shreg[BYTE_W-2:1]};
            bit_cnt  <= 3'd1;
            cur_port <= in_pn;
          end
        end
        S_COLLECT: begin
          if (!take) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            frag_q  <= (bit_cnt != 3'd0);
          end else begin
            frag_q   <= restart;
            shreg    <= {bit_in, shreg[BYTE_W-2:1]};
            bit_cnt  <= eff_cnt + 3'd1;
            cur_port <= in_pn;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_ok),
    .push_entry (push_entry),
    .pop        (pop),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .head       (head)
  );

  assign out_valid = !fifo_empty;
  assign out_port  = head.port;
  assign out_data  = head.data;
  assign overflow  = overflow_q;
  assign frag      = frag_q;

`ifdef BYTE_STATS_EN
  logic [15:0] stat_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) stat_q[i] <= '0;
    end else if (push_ok && (stat_q[push_entry.port] != 16'hFFFF)) begin
      stat_q[push_entry.port] <= stat_q[push_entry.port] + 16'd1;
    end
  end

  assign byte_cnt0 = stat_q[0];
  assign byte_cnt1 = stat_q[1];
  assign byte_cnt2 = stat_q[2];
  assign byte_cnt3 = stat_q[3];
`endif

endmodule

// File: tb/tb_port_byte_packer.sv
// Self-checking bench for port_byte_packer: table-driven bytes plus directed
// fragment/overflow/reset sequences, checked through an expected-entry queue.
module tb_port_byte_packer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_pn = 2'd0;
  logic [3:0] in_p = 4'd0;
  logic       in_error = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_port;
  logic [7:0] out_data;
  logic       overflow;
  logic       frag;
`ifdef BYTE_STATS_EN
  logic [15:0] bc0, bc1, bc2, bc3;
`endif

  port_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pn     (in_pn),
    .in_p      (in_p),
    .in_error  (in_error),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port),
    .out_data  (out_data),
    .overflow  (overflow),
    .frag      (frag)
`ifdef BYTE_STATS_EN
    ,
    .byte_cnt0 (bc0),
    .byte_cnt1 (bc1),
    .byte_cnt2 (bc2),
    .byte_cnt3 (bc3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    exp_t       exp;
    int         gap;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic pend_v = 1'b0;
  exp_t pend_e;
  logic exp_ovf = 1'b0;
  int   frag_cnt = 0;
  int   model_cnt[4] = '{0, 0, 0, 0};
  logic prev_hold = 1'b0;
  exp_t prev_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor / scoreboard, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (frag) frag_cnt++;
      if (prev_hold)
        chk("hold_stable", {22'd0, out_valid, out_port, out_data}, {22'd0, 1'b1, prev_head});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual=%0h required=none at %0t", {out_port, out_data}, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("entry", 32'({out_port, out_data}), 32'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_head = {out_port, out_data};
      if (pend_v) begin
        pend_v = 1'b0;
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(pend_e);
          model_cnt[pend_e.port]++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  task automatic drive_bit(input logic [1:0] pn, input logic b, input logic err);
    logic [3:0] p;
    p = 4'($urandom);
    p[pn] = b;
    in_valid = 1'b1;
    in_pn    = pn;
    in_p     = p;
    in_error = err;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_error = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_p  = 4'($urandom);
      in_pn = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [1:0] pn, input logic [7:0] d, input exp_t e,
                           input bit ready_last, input bit chk_lat);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        pend_v = 1'b1;
        pend_e = e;
        if (ready_last) out_ready = 1'b1;
        if (chk_lat) chk("latency_pre", 32'(out_valid), 32'd0);
      end
      drive_bit(pn, d[i], 1'b0);
      if (i == 7 && chk_lat) chk("latency_post", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic drain(input int max_cycles);
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d entries required=0", exp_q.size());
      exp_q.delete();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_stats();
`ifdef BYTE_STATS_EN
    chk("byte_cnt0", 32'(bc0), 32'(model_cnt[0]));
    chk("byte_cnt1", 32'(bc1), 32'(model_cnt[1]));
    chk("byte_cnt2", 32'(bc2), 32'(model_cnt[2]));
    chk("byte_cnt3", 32'(bc3), 32'(model_cnt[3]));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    pend_v  = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frag", 32'(frag), 32'd0);
    chk_stats();
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];
  int   f0;

  initial begin
    vecs[0] = '{port: 2'd0, data: 8'h00, exp: '{2'd0, 8'h00}, gap: 0};
    vecs[1] = '{port: 2'd1, data: 8'hFF, exp: '{2'd1, 8'hFF}, gap: 1};
    vecs[2] = '{port: 2'd3, data: 8'h81, exp: '{2'd3, 8'h81}, gap: 0};
    vecs[3] = '{port: 2'd2, data: 8'h7E, exp: '{2'd2, 8'h7E}, gap: 2};
    vecs[4] = '{port: 2'd0, data: 8'h96, exp: '{2'd0, 8'h96}, gap: 0};
    vecs[5] = '{port: 2'd3, data: 8'h01, exp: '{2'd3, 8'h01}, gap: 1};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // Two-byte packet on port 2, LSB first, with first-entry latency check.
    out_ready = 1'b1;
    f0 = frag_cnt;
    send_byte(2'd2, 8'hA5, '{2'd2, 8'hA5}, 1'b0, 1'b1);
    send_byte(2'd2, 8'h3C, '{2'd2, 8'h3C}, 1'b0, 1'b0);
    idle(3);
    chk("packet_no_frag", 32'(frag_cnt - f0), 32'd0);
    drain(50);

    // Table of bytes across ports, back-to-back and with gaps.
    f0 = frag_cnt;
    foreach (vecs[i]) begin
      send_byte(vecs[i].port, vecs[i].data, vecs[i].exp, 1'b0, 1'b0);
      idle(vecs[i].gap);
    end
    idle(2);
    chk("table_no_frag", 32'(frag_cnt - f0), 32'd0);
    drain(50);

    // in_valid drops after 5 bits.
    f0 = frag_cnt;
    for (int i = 0; i < 5; i++) drive_bit(2'd1, 1'($urandom), 1'b0);
    idle(3);
    chk("drop_frag", 32'(frag_cnt - f0), 32'd1);
    send_byte(2'd1, 8'h5A, '{2'd1, 8'h5A}, 1'b0, 1'b0);
    idle(2);
    drain(50);

    // Framing error mid-byte on port 1.
    f0 = frag_cnt;
    for (int i = 0; i < 4; i++) drive_bit(2'd1, 1'($urandom), 1'b0);
    drive_bit(2'd1, 1'b1, 1'b1);
    send_byte(2'd1, 8'hC3, '{2'd1, 8'hC3}, 1'b0, 1'b0);
    idle(2);
    chk("error_frag", 32'(frag_cnt - f0), 32'd1);
    drain(50);

    // Port change mid-byte restarts with the current bit.
    f0 = frag_cnt;
    for (int i = 0; i < 3; i++) drive_bit(2'd0, 1'($urandom), 1'b0);
    send_byte(2'd3, 8'h4D, '{2'd3, 8'h4D}, 1'b0, 1'b0);
    idle(2);
    chk("pn_change_frag", 32'(frag_cnt - f0), 32'd1);
    drain(50);

    // Five bytes into a depth-4 FIFO while the consumer stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_byte(2'(i), 8'(8'h11 * (i + 1)), '{2'(i), 8'(8'h11 * (i + 1))}, 1'b0, 1'b0);
    idle(2);
    chk("overflow_set", 32'(overflow), 32'(exp_ovf));
    chk("full_valid", 32'(out_valid), 32'd1);
    drain(60);
    chk("overflow_sticky", 32'(overflow), 32'(exp_ovf));
    chk_stats();

    // Full FIFO with a pop on the completing edge accepts the byte.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_byte(2'd2, 8'(8'hE0 + i), '{2'd2, 8'(8'hE0 + i)}, 1'b0, 1'b0);
    send_byte(2'd3, 8'h9B, '{2'd3, 8'h9B}, 1'b1, 1'b0);
    idle(2);
    chk("pop_push_no_overflow", 32'(overflow), 32'(exp_ovf));
    drain(60);
    chk_stats();

    // Reset mid-byte with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_byte(2'd1, 8'(8'h30 + i), '{2'd1, 8'(8'h30 + i)}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(2'd1, 1'($urandom), 1'b0);
    in_valid = 1'b1;
    do_reset();
    f0 = frag_cnt;
    idle(2);
    chk("post_rst_no_frag", 32'(frag_cnt - f0), 32'd0);
    send_byte(2'd0, 8'h6E, '{2'd0, 8'h6E}, 1'b0, 1'b0);
    idle(1);
    drain(50);
    chk_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
